// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default payload width and the
// register-slice occupancy states.
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Number of beats held for a given state; the illegal encoding holds nothing.
  function automatic logic [1:0] buf_occ(buf_state_t s);
    case (s)
      ONE:     buf_occ = 2'd1;
      FULL:    buf_occ = 2'd2;
      default: buf_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/buffer_if.sv
// AXI-Stream link through the register slice: upstream (t*_i in, tready_o out)
// and downstream (t*_o out, tready_i in) grouped in one bundle.
interface buffer_if #(
  parameter int DATA_WIDTH = axis_pkg::AXIS_DATA_WIDTH
);
  logic                  tvalid_i;
  logic                  tready_o;
  logic [DATA_WIDTH-1:0] tdata_i;
  logic                  tready_i;
  logic                  tvalid_o;
  logic [DATA_WIDTH-1:0] tdata_o;

  modport slave (
    input  tvalid_i, tdata_i, tready_i,
    output tready_o, tvalid_o, tdata_o
  );

  modport master (
    output tvalid_i, tdata_i, tready_i,
    input  tready_o, tvalid_o, tdata_o
  );
endinterface

// File: rtl/buffer.sv
// AXI-Stream skid buffer: depth-2 FIFO whose tvalid_o, tdata_o and tready_o
// all come directly from flops, sustaining one beat per clock.
module buffer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic     clk_i,
  input  logic     arstn_i,
  buffer_if.slave  bus
);

  buf_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tready_q, tready_d;
  logic                  in_xfer, out_xfer;

  assign in_xfer  = bus.tvalid_i & tready_q;
  assign out_xfer = tvalid_q & bus.tready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = bus.tdata_i;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = bus.tdata_i;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = bus.tdata_i;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs are registered from the next state, so they carry no
    // combinational path from tvalid_i/tready_i.
    tvalid_d = (state_d != EMPTY);
    tready_d = (state_d != FULL);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      tvalid_q <= 1'b0;
      tready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
    end
  end

  assign bus.tvalid_o = tvalid_q;
  assign bus.tready_o = tready_q;
  assign bus.tdata_o  = main_q;

`ifndef SYNTHESIS
  int unsigned in_cnt_q, out_cnt_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      in_cnt_q  <= 0;
      out_cnt_q <= 0;
    end else begin
      assert ((in_cnt_q - out_cnt_q) == 32'(buf_occ(state_q)) && buf_occ(state_q) <= 2'd2)
        else $error("buffer: beat count %0d in / %0d out disagrees with occupancy",
                    in_cnt_q, out_cnt_q);
      in_cnt_q  <= in_cnt_q + 32'(in_xfer);
      out_cnt_q <= out_cnt_q + 32'(out_xfer);
    end
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!arstn_i)
    (bus.tvalid_o && !bus.tready_i) |=> $stable(bus.tdata_o));
`endif

endmodule

// File: tb/tb_buffer.sv
// Directed bench for the skid buffer: inputs change on the falling edge,
// outputs are checked 1 ns before the next rising edge.
module tb_buffer;
  import axis_pkg::*;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;

  buffer_if #(.DATA_WIDTH(4)) bus ();

  buffer #(.DATA_WIDTH(4)) dut (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp)
      else begin
        n_err++;
        $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
  endtask

  // Drive one cycle of inputs on the falling edge, then wait until just before
  // the rising edge that samples them.
  task automatic cyc(input logic tv, input logic [3:0] td, input logic tr);
    @(negedge clk_i);
    bus.tvalid_i = tv;
    bus.tdata_i  = td;
    bus.tready_i = tr;
    #4;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic r);
    chk({tag, ".tvalid"}, {7'd0, bus.tvalid_o}, {7'd0, v});
    chk({tag, ".tdata"},  {4'd0, bus.tdata_o},  {4'd0, d});
    chk({tag, ".tready"}, {7'd0, bus.tready_o}, {7'd0, r});
  endtask

  logic [3:0] strm [5];

  initial begin
    bus.tvalid_i = 1'b0;
    bus.tdata_i  = 4'h0;
    bus.tready_i = 1'b0;
    strm = '{4'h3, 4'h9, 4'h3, 4'hE, 4'h8};

    // 1: long reset
    repeat (40) @(negedge clk_i);
    #4;
    chk_out("reset", 1'b0, 4'h0, 1'b1);
    @(negedge clk_i);
    arstn_i = 1'b1;

    // 2: fill under back-pressure; third beat refused
    cyc(1'b1, 4'h1, 1'b0);
    chk_out("fill0", 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'h8, 1'b0);
    chk_out("fill1", 1'b1, 4'h1, 1'b1);
    cyc(1'b1, 4'h5, 1'b0);
    chk_out("fill2", 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("fill3", 1'b1, 4'h1, 1'b0);

    // 3: drain FULL(0x1,0x8); the refused 0x5 must not appear
    cyc(1'b0, 4'h0, 1'b1);
    chk_out("drain0", 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    chk_out("drain1", 1'b1, 4'h8, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("drain2", 1'b0, 4'h8, 1'b1);

    // reset asserted mid-FULL takes effect without a clock edge
    cyc(1'b1, 4'h2, 1'b0);
    cyc(1'b1, 4'h7, 1'b0);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("full2", 1'b1, 4'h2, 1'b0);
    arstn_i = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 4'h0, 1'b1);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;

    // 4: streaming at one beat per clock
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, strm[i], 1'b1);
      chk("strm.tready", {7'd0, bus.tready_o}, 8'd1);
      if (i > 0) begin
        chk("strm.tvalid", {7'd0, bus.tvalid_o}, 8'd1);
        chk("strm.tdata",  {4'd0, bus.tdata_o},  {4'd0, strm[i-1]});
      end
    end
    cyc(1'b0, 4'h0, 1'b1);
    chk_out("strm_end", 1'b1, 4'h8, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("strm_idle", 1'b0, 4'h8, 1'b1);

    // 5: simultaneous in/out in ONE, then hold under back-pressure
    cyc(1'b1, 4'hC, 1'b0);
    cyc(1'b1, 4'hD, 1'b1);
    chk_out("sim0", 1'b1, 4'hC, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("sim1", 1'b1, 4'hD, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("sim2", 1'b1, 4'hD, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // 6: idle input with toggling data is ignored
    cyc(1'b0, 4'h4, 1'b0);
    chk_out("idle0", 1'b0, 4'hD, 1'b1);
    cyc(1'b0, 4'hB, 1'b1);
    chk_out("idle1", 1'b0, 4'hD, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk_out("idle2", 1'b0, 4'hD, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
